// File: rtl/single_cycle_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : single_cycle_cpu (with cpu_imem, cpu_regfile, cpu_dmem)
//  Description : Single-cycle 32-bit MIPS-subset core. Fetch, decode,
//                execute, memory access and writeback complete in one clock.
//                No branches or jumps; the PC advances by 4 every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================

// Instruction memory: combinational read, contents loaded externally.
module cpu_imem #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic [AW-1:0] i_idx,
    output logic [31:0]   o_data
);
    logic [31:0] insMem [0:WORDS-1];

    assign o_data = insMem[i_idx];
endmodule

// 32x32 register file: two async read ports, one sync write port, r0 fixed 0.
module cpu_regfile (
    input  logic        clk,
    input  logic        rst,     // active-low, asynchronous
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] rf [0:31];

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : rf[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : rf[i_ra2];

    // Clear on reset; writes aimed at r0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            rf[i_wa] <= i_wd;
        end
    end
endmodule

// Word-organised data memory with per-byte write enables, async read.
module cpu_dmem #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,     // active-low, asynchronous
    input  logic [AW-1:0] i_idx,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] dataMem [0:WORDS-1];

    assign o_rdata = dataMem[i_idx];

    // Clear on reset; otherwise update only the enabled byte lanes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) dataMem[i] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (i_be[k]) dataMem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end
endmodule

module single_cycle_cpu #(
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter logic [31:0] DATA_BASE  = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024
) (
    input  logic clk,
    input  logic rst      // active-low, asynchronous
);
    localparam int c_imem_aw = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int c_dmem_aw = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lb    = 6'h20;
    localparam logic [5:0] c_op_lh    = 6'h21;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_lbu   = 6'h24;
    localparam logic [5:0] c_op_lhu   = 6'h25;
    localparam logic [5:0] c_op_sb    = 6'h28;
    localparam logic [5:0] c_op_sh    = 6'h29;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sra  = 6'h03;
    localparam logic [5:0] c_fn_sllv = 6'h04;
    localparam logic [5:0] c_fn_srlv = 6'h06;
    localparam logic [5:0] c_fn_srav = 6'h07;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    logic [31:0] PC;
    logic [31:0] pc_d;
    logic [31:0] inst;

    logic [31:0] w_pc_off;
    logic [31:0] w_ea;
    logic [31:0] w_ea_off;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [15:0] w_imm;
    logic [31:0] w_simm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_ld_word;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic        w_rf_we;
    logic [4:0]  w_rf_wa;
    logic [31:0] w_rf_wd;
    logic [3:0]  w_be;
    logic [31:0] w_st_data;
    logic        w_unused;

    assign w_op     = inst[31:26];
    assign w_rs     = inst[25:21];
    assign w_rt     = inst[20:16];
    assign w_rd     = inst[15:11];
    assign w_shamt  = inst[10:6];
    assign w_funct  = inst[5:0];
    assign w_imm    = inst[15:0];
    assign w_simm   = {{16{w_imm[15]}}, w_imm};

    assign w_pc_off = PC - TEXT_BASE;
    assign w_ea     = w_rs_val + w_simm;
    assign w_ea_off = w_ea - DATA_BASE;
    // Offset bits above the memory depth and below word granularity are dropped
    assign w_unused = ^{w_pc_off, w_ea_off};

    cpu_imem #(.WORDS(IMEM_WORDS), .AW(c_imem_aw)) insMem (
        .i_idx  (w_pc_off[c_imem_aw+1:2]),
        .o_data (inst)
    );

    cpu_regfile regFile (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_we  (w_rf_we),
        .i_wa  (w_rf_wa),
        .i_wd  (w_rf_wd),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val)
    );

    cpu_dmem #(.WORDS(DMEM_WORDS), .AW(c_dmem_aw)) dataMem (
        .clk     (clk),
        .rst     (rst),
        .i_idx   (w_ea_off[c_dmem_aw+1:2]),
        .i_be    (w_be),
        .i_wdata (w_st_data),
        .o_rdata (w_ld_word)
    );

    // Next PC: straight-line fetch, wraps naturally at 2^32
    always_comb begin
        pc_d = PC + 32'd4;
    end

    // PC register: async reset to the text base
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) PC <= TEXT_BASE;
        else      PC <= pc_d;
    end

    // Load lane extraction: byte by EA[1:0], halfword by EA[1]
    always_comb begin
        w_ld_byte = w_ld_word[7:0];
        case (w_ea[1:0])
            2'd1:    w_ld_byte = w_ld_word[15:8];
            2'd2:    w_ld_byte = w_ld_word[23:16];
            2'd3:    w_ld_byte = w_ld_word[31:24];
            default: w_ld_byte = w_ld_word[7:0];
        endcase
        w_ld_half = w_ea[1] ? w_ld_word[31:16] : w_ld_word[15:0];
    end

    // Decode/execute: register writeback and store byte enables; unknown ops are NOPs
    always_comb begin
        w_rf_we   = 1'b0;
        w_rf_wa   = w_rt;
        w_rf_wd   = '0;
        w_be      = 4'b0000;
        w_st_data = w_rt_val;
        case (w_op)
            c_op_rtype: begin
                w_rf_we = 1'b1;
                w_rf_wa = w_rd;
                case (w_funct)
                    c_fn_add, c_fn_addu: w_rf_wd = w_rs_val + w_rt_val;
                    c_fn_sub, c_fn_subu: w_rf_wd = w_rs_val - w_rt_val;
                    c_fn_and:  w_rf_wd = w_rs_val & w_rt_val;
                    c_fn_or:   w_rf_wd = w_rs_val | w_rt_val;
                    c_fn_nor:  w_rf_wd = ~(w_rs_val | w_rt_val);
                    c_fn_slt:  w_rf_wd = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
                    c_fn_sltu: w_rf_wd = {31'd0, w_rs_val < w_rt_val};
                    c_fn_sll:  w_rf_wd = w_rt_val << w_shamt;
                    c_fn_srl:  w_rf_wd = w_rt_val >> w_shamt;
                    c_fn_sra:  w_rf_wd = $signed(w_rt_val) >>> w_shamt;
                    c_fn_sllv: w_rf_wd = w_rt_val << w_rs_val[4:0];
                    c_fn_srlv: w_rf_wd = w_rt_val >> w_rs_val[4:0];
                    c_fn_srav: w_rf_wd = $signed(w_rt_val) >>> w_rs_val[4:0];
                    default:   w_rf_we = 1'b0;
                endcase
            end
            c_op_addi: begin w_rf_we = 1'b1; w_rf_wd = w_rs_val + w_simm;             end
            c_op_ori:  begin w_rf_we = 1'b1; w_rf_wd = w_rs_val | {16'd0, w_imm};    end
            c_op_lui:  begin w_rf_we = 1'b1; w_rf_wd = {w_imm, 16'd0};               end
            c_op_lw:   begin w_rf_we = 1'b1; w_rf_wd = w_ld_word;                    end
            c_op_lh:   begin w_rf_we = 1'b1; w_rf_wd = {{16{w_ld_half[15]}}, w_ld_half}; end
            c_op_lhu:  begin w_rf_we = 1'b1; w_rf_wd = {16'd0, w_ld_half};           end
            c_op_lb:   begin w_rf_we = 1'b1; w_rf_wd = {{24{w_ld_byte[7]}}, w_ld_byte}; end
            c_op_lbu:  begin w_rf_we = 1'b1; w_rf_wd = {24'd0, w_ld_byte};           end
            c_op_sw:   begin w_be = 4'b1111; end
            c_op_sh:   begin
                w_be      = w_ea[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{w_rt_val[15:0]}};
            end
            c_op_sb:   begin
                w_be      = 4'b0001 << w_ea[1:0];
                w_st_data = {4{w_rt_val[7:0]}};
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_single_cycle_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_single_cycle_cpu
//  Description : Self-checking bench for single_cycle_cpu. Directed programs
//                for each instruction class plus a random instruction stream
//                checked against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_single_cycle_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    single_cycle_cpu #(
        .TEXT_BASE  (32'h0000_3000),
        .DATA_BASE  (32'h0000_0000),
        .IMEM_WORDS (1024),
        .DMEM_WORDS (1024)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural reference state
    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [1024];
    logic [31:0] m_pc;
    int          m_last_st;

    logic [5:0] c_fns     [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A,
                                   6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] c_lds     [5]  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] c_sts     [3]  = '{6'h28, 6'h29, 6'h2B};
    logic [5:0] c_bad_ops [6]  = '{6'h02, 6'h04, 6'h05, 6'h0A, 6'h0C, 6'h3F};
    logic [5:0] c_bad_fns [5]  = '{6'h01, 6'h05, 6'h08, 6'h0C, 6'h1A};

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        logic [4:0] a, b, d, s;
        a = rs[4:0]; b = rt[4:0]; d = rd[4:0]; s = sh[4:0];
        return {6'h00, a, b, d, s, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] a, b;
        a = rs[4:0]; b = rt[4:0];
        return {op, a, b, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++)   m_rf[i]  = 32'd0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
        m_pc      = 32'h0000_3000;
        m_last_st = -1;
    endtask

    // Instruction-level semantics, written straight from the ISA rules
    task automatic model_step(input logic [31:0] ins);
        logic [5:0]  op, fn;
        int          rs, rt, rd, sh, idx, k, dst;
        logic [31:0] a, b, simm, ea, word, res;
        logic [7:0]  by;
        logic [15:0] hw;
        bit          wr;
        op = ins[31:26]; fn = ins[5:0];
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
        a = m_rf[rs]; b = m_rf[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        ea   = a + simm;
        idx  = int'((ea >> 2) % 1024);
        k    = int'(ea % 4);
        word = m_mem[idx];
        by   = word[8*k +: 8];
        hw   = word[16*(k/2) +: 16];
        wr = 1'b1; dst = rt; res = 32'd0;
        m_last_st = -1;
        case (op)
            6'h00: begin
                dst = rd;
                case (fn)
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $signed(b) >>> sh;
                    6'h04: res = b << (a % 32);
                    6'h06: res = b >> (a % 32);
                    6'h07: res = $signed(b) >>> (a % 32);
                    default: wr = 1'b0;
                endcase
            end
            6'h08: res = a + simm;
            6'h0D: res = a | {16'd0, ins[15:0]};
            6'h0F: res = {ins[15:0], 16'd0};
            6'h23: res = word;
            6'h21: res = {{16{hw[15]}}, hw};
            6'h25: res = {16'd0, hw};
            6'h20: res = {{24{by[7]}}, by};
            6'h24: res = {24'd0, by};
            6'h2B: begin wr = 1'b0; m_mem[idx] = b; m_last_st = idx; end
            6'h29: begin wr = 1'b0; m_mem[idx][16*(k/2) +: 16] = b[15:0]; m_last_st = idx; end
            6'h28: begin wr = 1'b0; m_mem[idx][8*k +: 8] = b[7:0]; m_last_st = idx; end
            default: wr = 1'b0;
        endcase
        if (wr && dst != 0) m_rf[dst] = res;
        m_pc = m_pc + 32'd4;
    endtask

    // Place one instruction at the current PC, run it for one clock
    task automatic exec(input logic [31:0] ins);
        logic [31:0] off;
        off = m_pc - 32'h0000_3000;
        dut.insMem.insMem[off[11:2]] = ins;
        model_step(ins);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        #1;
        n_checks++;
        if (dut.PC !== 32'h0000_3000) $display("FAIL pc_async_reset: got %h expected %h", dut.PC, 32'h3000);
        else n_pass++;
        @(posedge clk);
        #7;
        n_checks++;
        if (dut.PC !== 32'h0000_3000) $display("FAIL pc_held_in_reset: got %h expected %h", dut.PC, 32'h3000);
        else n_pass++;
        #6;
        rst = 1'b1;
        bad = -1;
        for (int i = 0; i < 32; i++) if (dut.regFile.rf[i] !== 32'd0 && bad < 0) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL rf_reset: rf[%0d] got %h expected 0", bad, dut.regFile.rf[bad]);
        else n_pass++;
        bad = -1;
        for (int i = 0; i < 1024; i++) if (dut.dataMem.dataMem[i] !== 32'd0 && bad < 0) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL dmem_reset: m[%0d] got %h expected 0", bad, dut.dataMem.dataMem[bad]);
        else n_pass++;
        exec(32'h0);
        n_checks++;
        if (dut.PC !== 32'h0000_3004) $display("FAIL pc_first_edge: got %h expected %h", dut.PC, 32'h3004);
        else n_pass++;
        exec(32'h0);
        exec(32'h0);
        n_checks++;
        if (dut.PC !== 32'h0000_300C) $display("FAIL pc_increment: got %h expected %h", dut.PC, 32'h300C);
        else n_pass++;
    endtask

    task automatic test_immediate();
        exec(itype(6'h0F, 0, 1, 16'h1234));
        n_checks++;
        if (dut.regFile.rf[1] !== 32'h1234_0000) $display("FAIL lui: got %h expected %h", dut.regFile.rf[1], 32'h12340000);
        else n_pass++;
        exec(itype(6'h0D, 1, 1, 16'h5678));
        exec(itype(6'h08, 0, 2, 16'hFFFF));
        n_checks++;
        if (dut.regFile.rf[1] !== 32'h1234_5678) $display("FAIL ori: got %h expected %h", dut.regFile.rf[1], 32'h12345678);
        else n_pass++;
        n_checks++;
        if (dut.regFile.rf[2] !== 32'hFFFF_FFFF) $display("FAIL addi_neg: got %h expected %h", dut.regFile.rf[2], 32'hFFFFFFFF);
        else n_pass++;
    endtask

    task automatic test_alu();
        logic [31:0] exp_v [9];
        int          regs  [9];
        exec(rtype(1, 2, 3, 0, 6'h21));
        exec(rtype(1, 2, 4, 0, 6'h23));
        exec(rtype(1, 0, 5, 0, 6'h27));
        exec(rtype(2, 1, 6, 0, 6'h2A));
        exec(rtype(2, 1, 7, 0, 6'h2B));
        exec(rtype(1, 2, 15, 0, 6'h24));
        exec(rtype(1, 0, 16, 0, 6'h25));
        exec(itype(6'h0F, 0, 18, 16'h7FFF));
        exec(itype(6'h0D, 18, 18, 16'hFFFF));
        exec(rtype(18, 18, 17, 0, 6'h20));
        exec(itype(6'h08, 18, 20, 16'h0001));
        exec(itype(6'h0F, 0, 21, 16'h8000));
        exec(rtype(21, 18, 22, 0, 6'h22));
        regs  = '{3, 4, 5, 6, 7, 15, 16, 17, 20};
        exp_v = '{32'h12345677, 32'h12345679, 32'hEDCBA987, 32'd1, 32'd0,
                  32'h12345678, 32'h12345678, 32'hFFFFFFFE, 32'h80000000};
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (dut.regFile.rf[regs[i]] !== exp_v[i])
                $display("FAIL alu_r%0d: got %h expected %h", regs[i], dut.regFile.rf[regs[i]], exp_v[i]);
            else n_pass++;
        end
        n_checks++;
        if (dut.regFile.rf[22] !== 32'd1) $display("FAIL sub_overflow: got %h expected %h", dut.regFile.rf[22], 32'd1);
        else n_pass++;
    endtask

    task automatic test_shift();
        logic [31:0] ins   [6];
        logic [31:0] exp_v [6];
        exec(itype(6'h08, 0, 9, 16'd4));
        ins   = '{rtype(0, 1, 8, 4, 6'h00), rtype(0, 2, 8, 28, 6'h02), rtype(0, 2, 8, 4, 6'h03),
                  rtype(9, 1, 8, 0, 6'h04), rtype(9, 2, 8, 0, 6'h06), rtype(9, 2, 8, 0, 6'h07)};
        exp_v = '{32'h23456780, 32'h0000000F, 32'hFFFFFFFF,
                  32'h23456780, 32'h0FFFFFFF, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            exec(ins[i]);
            n_checks++;
            if (dut.regFile.rf[8] !== exp_v[i])
                $display("FAIL shift_%0d: got %h expected %h", i, dut.regFile.rf[8], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_store();
        exec(itype(6'h2B, 0, 1, 16'd0));
        exec(itype(6'h29, 0, 1, 16'd6));
        exec(itype(6'h28, 0, 1, 16'd9));
        n_checks++;
        if (dut.dataMem.dataMem[0] !== 32'h12345678) $display("FAIL sw: got %h expected %h", dut.dataMem.dataMem[0], 32'h12345678);
        else n_pass++;
        n_checks++;
        if (dut.dataMem.dataMem[1] !== 32'h56780000) $display("FAIL sh_upper: got %h expected %h", dut.dataMem.dataMem[1], 32'h56780000);
        else n_pass++;
        n_checks++;
        if (dut.dataMem.dataMem[2] !== 32'h00007800) $display("FAIL sb_lane1: got %h expected %h", dut.dataMem.dataMem[2], 32'h00007800);
        else n_pass++;
    endtask

    task automatic test_load();
        int          regs  [5];
        logic [31:0] exp_v [5];
        exec(itype(6'h0F, 0, 19, 16'h8000));
        exec(itype(6'h0D, 19, 19, 16'hFF80));
        exec(itype(6'h2B, 0, 19, 16'd12));
        exec(itype(6'h23, 0, 10, 16'd0));
        exec(itype(6'h20, 0, 11, 16'd12));
        exec(itype(6'h24, 0, 12, 16'd12));
        exec(itype(6'h21, 0, 13, 16'd14));
        exec(itype(6'h25, 0, 14, 16'd14));
        regs  = '{10, 11, 12, 13, 14};
        exp_v = '{32'h12345678, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (dut.regFile.rf[regs[i]] !== exp_v[i])
                $display("FAIL load_r%0d: got %h expected %h", regs[i], dut.regFile.rf[regs[i]], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_r0_and_illegal();
        logic [31:0] ins [4];
        logic [31:0] snap;
        ins = '{itype(6'h08, 0, 0, 16'd5), itype(6'h23, 0, 0, 16'd0),
                itype(6'h0F, 0, 0, 16'hABCD), rtype(1, 2, 0, 0, 6'h21)};
        for (int i = 0; i < 4; i++) begin
            exec(ins[i]);
            n_checks++;
            if (dut.regFile.rf[0] !== 32'd0) $display("FAIL r0_write_%0d: got %h expected 0", i, dut.regFile.rf[0]);
            else n_pass++;
        end
        snap = dut.regFile.rf[1];
        exec({6'h3F, 5'd0, 5'd1, 16'h0001});
        exec(rtype(0, 0, 1, 0, 6'h01));
        n_checks++;
        if (dut.regFile.rf[1] !== 32'h12345678 || snap !== 32'h12345678)
            $display("FAIL illegal_nop: got %h expected %h", dut.regFile.rf[1], 32'h12345678);
        else n_pass++;
        n_checks++;
        if (dut.PC !== m_pc) $display("FAIL illegal_pc: got %h expected %h", dut.PC, m_pc);
        else n_pass++;
    endtask

    function automatic logic [31:0] rand_instr();
        int          sel;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        sel = int'($urandom_range(0, 99));
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        imm = 16'($urandom);
        if (sel >= 60 && sel < 84 && $urandom_range(0, 1) == 1) begin
            rs  = 5'd0;
            imm = 16'($urandom_range(0, 63));
        end
        if (sel < 40)      return {6'h00, rs, rt, rd, sh, c_fns[$urandom_range(0, 14)]};
        else if (sel < 50) return {6'h08, rs, rt, imm};
        else if (sel < 55) return {6'h0D, rs, rt, imm};
        else if (sel < 60) return {6'h0F, rs, rt, imm};
        else if (sel < 72) return {c_lds[$urandom_range(0, 4)], rs, rt, imm};
        else if (sel < 84) return {c_sts[$urandom_range(0, 2)], rs, rt, imm};
        else if (sel < 92) return {c_bad_ops[$urandom_range(0, 5)], rs, rt, imm};
        else               return {6'h00, rs, rt, rd, sh, c_bad_fns[$urandom_range(0, 4)]};
    endfunction

    task automatic test_random();
        logic [31:0] ins;
        int          bad;
        for (int n = 0; n < 400; n++) begin
            ins = rand_instr();
            exec(ins);
            bad = -1;
            for (int r = 0; r < 32; r++) if (dut.regFile.rf[r] !== m_rf[r] && bad < 0) bad = r;
            n_checks++;
            if (bad >= 0)
                $display("FAIL rand_rf step %0d ins %h: rf[%0d] got %h expected %h",
                         n, ins, bad, dut.regFile.rf[bad], m_rf[bad]);
            else n_pass++;
            n_checks++;
            if (dut.PC !== m_pc) $display("FAIL rand_pc step %0d: got %h expected %h", n, dut.PC, m_pc);
            else n_pass++;
            if (m_last_st >= 0) begin
                n_checks++;
                if (dut.dataMem.dataMem[m_last_st] !== m_mem[m_last_st])
                    $display("FAIL rand_store step %0d ins %h: m[%0d] got %h expected %h",
                             n, ins, m_last_st, dut.dataMem.dataMem[m_last_st], m_mem[m_last_st]);
                else n_pass++;
            end
        end
        bad = -1;
        for (int i = 0; i < 1024; i++) if (dut.dataMem.dataMem[i] !== m_mem[i] && bad < 0) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL rand_dmem: m[%0d] got %h expected %h", bad, dut.dataMem.dataMem[bad], m_mem[bad]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int bad;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (dut.PC !== 32'h0000_3000) $display("FAIL midrun_reset_pc: got %h expected %h", dut.PC, 32'h3000);
        else n_pass++;
        bad = -1;
        for (int i = 0; i < 32; i++) if (dut.regFile.rf[i] !== 32'd0 && bad < 0) bad = i;
        for (int i = 0; i < 1024; i++) if (dut.dataMem.dataMem[i] !== 32'd0 && bad < 0) bad = 100 + i;
        n_checks++;
        if (bad >= 0) $display("FAIL midrun_reset_clear: first nonzero location code %0d", bad);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.PC !== 32'h0000_3000) $display("FAIL midrun_reset_hold: got %h expected %h", dut.PC, 32'h3000);
        else n_pass++;
        #3;
        rst = 1'b1;
        model_reset();
        exec(itype(6'h08, 0, 1, 16'd7));
        n_checks++;
        if (dut.regFile.rf[1] !== 32'd7 || dut.PC !== 32'h0000_3004)
            $display("FAIL post_reset_exec: r1 %h pc %h expected r1 %h pc %h", dut.regFile.rf[1], dut.PC, 32'd7, 32'h3004);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dut.insMem.insMem[i] = 32'h0;
        model_reset();
        #1 rst = 1'b0;
        test_reset();
        test_immediate();
        test_alu();
        test_shift();
        test_store();
        test_load();
        test_r0_and_illegal();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
